fetch_ctrl: RTL

Sequences AXI4 read-address bursts for the instruction fetch path.
- Drives the read-address channel and supplies the per-beat fetch_pc consumed by the instruction buffer alongside rdata.
- Throttles on buffer-full.
- Handles branch/jump redirects by draining in-flight bursts and restarting at the target.
- Sits between the branch unit, the instruction buffer and the AXI instruction memory port.

---
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: AXI4 read-address burst sequencer for instruction fetch.
// Optional perf counters enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    input  logic        rvalid,
    input  logic        rready,
    input  logic        rlast,
    input  logic        buf_full,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    output logic [31:0] fetch_pc,
    output logic        flush,
    output logic        jump_accept,
    output logic        busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] next_addr;
    logic [31:0] tgt;
    logic        jump_pend;

    logic        beat;
    logic        last_beat;
    logic [31:0] jump_tgt;
    logic [31:0] drain_tgt;
    logic [10:0] words_left;
    logic [7:0]  burst_arlen;
    logic [31:0] burst_end;

    assign beat      = rvalid & rready;
    assign last_beat = beat & rlast;
    assign jump_tgt  = jump_pc & 32'hFFFF_FFFC;
    assign drain_tgt = jump ? jump_tgt : tgt;
    assign busy      = (state != IDLE);

    // Words left before the next 4 KB page; clamps burst length so it never crosses.
    assign words_left = 11'd1024 - {1'b0, next_addr[11:2]};
    assign burst_end  = araddr + {21'd0, ({1'b0, arlen} + 9'd1), 2'b00};

    // Burst length for the next request, shortened at a page boundary.
    always_comb begin
        burst_arlen = 8'(BURST_LEN - 1);
        if (words_left < 11'(BURST_LEN))
            burst_arlen = words_left[7:0] - 8'd1;
    end

    // Main fetch sequencer: issue bursts, track beat PCs, drain on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            arvalid     <= 1'b0;
            araddr      <= RESET_PC;
            arlen       <= 8'd0;
            fetch_pc    <= RESET_PC;
            flush       <= 1'b0;
            jump_accept <= 1'b0;
            next_addr   <= RESET_PC;
            tgt         <= RESET_PC;
            jump_pend   <= 1'b0;
        end else begin
            jump_accept <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (jump) begin
                        next_addr   <= jump_tgt;
                        fetch_pc    <= jump_tgt;
                        jump_accept <= 1'b1;
                    end else if (!buf_full) begin
                        state   <= ADDR;
                        arvalid <= 1'b1;
                        araddr  <= next_addr;
                        arlen   <= burst_arlen;
                    end
                end
                ADDR: begin
                    if (jump) begin
                        jump_pend <= 1'b1;
                        tgt       <= jump_tgt;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        if (jump || jump_pend) begin
                            state <= DRAIN;
                            flush <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (beat)
                        fetch_pc <= fetch_pc + 32'd4;
                    if (last_beat) begin
                        state <= IDLE;
                        if (jump) begin
                            next_addr   <= jump_tgt;
                            fetch_pc    <= jump_tgt;
                            jump_accept <= 1'b1;
                        end else begin
                            next_addr <= burst_end;
                        end
                    end else if (jump) begin
                        tgt   <= jump_tgt;
                        flush <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (jump)
                        tgt <= jump_tgt;
                    if (last_beat) begin
                        next_addr   <= drain_tgt;
                        fetch_pc    <= drain_tgt;
                        jump_accept <= 1'b1;
                        flush       <= 1'b0;
                        jump_pend   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    // Saturating counters: idle stall cycles and discarded beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (state == IDLE && buf_full && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (state == DRAIN && beat && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
